// File: rtl/stack_arbiter.sv
// stack_arbiter
//   Round-robin arbiter that lets two requesters share one external stack.
//   After reset the stack is cleared once (INIT). Then one request at a time
//   is accepted, checked for legality against the stack status, issued to
//   the stack for one cycle and answered with a done/err pulse.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req*/cmd*/din*           requester 0/1 request, command, push data
//   gnt*                     one-cycle grant pulse on acceptance
//   done*/err*               one-cycle completion pulse, error valid with done
//   dout                     last successfully popped value
//   stk_cmd/stk_din          command and data driven to the stack
//   stk_dout                 stack read data
//   stk_full/empty/error     stack status
//
// state   | meaning
// --------+---------------------------------------------------------
// S_INIT  | issue one CLEAR to the stack, requests ignored
// S_IDLE  | wait for a request, arbitrate, latch and check legality
// S_ISSUE | drive latched command/data to the stack for one cycle
// S_RESP  | pulse done/err to the latched requester, capture pop data

module stack_arbiter #(
    parameter int         DATA_W    = 8,
    parameter logic [1:0] CMD_NOOP  = 2'b00,
    parameter logic [1:0] CMD_CLEAR = 2'b01,
    parameter logic [1:0] CMD_PUSH  = 2'b10,
    parameter logic [1:0] CMD_POP   = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        stk_cmd,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    input  logic              stk_full,
    input  logic              stk_empty,
    input  logic              stk_error
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state;
    logic              last_served;
    logic              lat_id;
    logic              lat_rej;
    logic [1:0]        lat_cmd;
    logic [DATA_W-1:0] stk_din_q;

    logic              any_req;
    logic              win;
    logic [1:0]        win_cmd;
    logic [DATA_W-1:0] win_din;
    logic              win_rej;

    // On a tie the requester that was not served last wins.
    assign any_req = req0 | req1;
    assign win     = (req0 && req1) ? ~last_served : req1;
    assign win_cmd = win ? cmd1 : cmd0;
    assign win_din = win ? din1 : din0;
    assign win_rej = ((win_cmd == CMD_PUSH) && stk_full) ||
                     ((win_cmd == CMD_POP)  && stk_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            dout        <= '0;
            last_served <= 1'b1;
            lat_id      <= 1'b0;
            lat_rej     <= 1'b0;
            lat_cmd     <= CMD_NOOP;
            stk_din_q   <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                S_INIT: begin
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (any_req) begin
                        lat_id      <= win;
                        lat_cmd     <= win_cmd;
                        lat_rej     <= win_rej;
                        last_served <= win;
                        gnt0        <= ~win;
                        gnt1        <= win;
                        if (win_rej) begin
                            state <= S_RESP;
                        end else begin
                            // Only loaded for legal ops so stk_din holds outside ISSUE.
                            stk_din_q <= win_din;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (lat_id) begin
                        done1 <= 1'b1;
                        err1  <= lat_rej | stk_error;
                    end else begin
                        done0 <= 1'b1;
                        err0  <= lat_rej | stk_error;
                    end
                    if (!lat_rej && (lat_cmd == CMD_POP)) begin
                        dout <= stk_dout;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // Reset forces NOOP immediately, even mid-issue.
    always_comb begin
        stk_cmd = CMD_NOOP;
        if (!rst) begin
            if (state == S_INIT) begin
                stk_cmd = CMD_CLEAR;
            end else if (state == S_ISSUE) begin
                stk_cmd = lat_cmd;
            end
        end
    end

    assign stk_din = stk_din_q;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    localparam int         DW    = 8;
    localparam int         DEPTH = 4;
    localparam logic [1:0] NOOP  = 2'b00;
    localparam logic [1:0] CLR   = 2'b01;
    localparam logic [1:0] PUSH  = 2'b10;
    localparam logic [1:0] POP   = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [1:0]    cmd0 = NOOP, cmd1 = NOOP;
    logic [DW-1:0] din0 = '0, din1 = '0;
    logic          gnt0, gnt1, done0, done1, err0, err1;
    logic [DW-1:0] dout;
    logic [1:0]    stk_cmd;
    logic [DW-1:0] stk_din;
    logic [DW-1:0] stk_dout = '0;
    logic          stk_full, stk_empty, stk_error;
    logic          inject = 1'b0;

    stack_arbiter #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .dout(dout),
        .stk_cmd(stk_cmd), .stk_din(stk_din), .stk_dout(stk_dout),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error)
    );

    always #5 clk = ~clk;

    // Behavioural stack attached to the DUT.
    logic [DW-1:0] mem [DEPTH];
    int            s_cnt = 0;
    assign stk_full  = (s_cnt == DEPTH);
    assign stk_empty = (s_cnt == 0);
    assign stk_error = inject;

    always @(posedge clk) begin
        case (stk_cmd)
            CLR:  s_cnt <= 0;
            PUSH: if (s_cnt < DEPTH) begin mem[s_cnt] <= stk_din; s_cnt <= s_cnt + 1; end
            POP:  if (s_cnt > 0) begin stk_dout <= mem[s_cnt-1]; s_cnt <= s_cnt - 1; end
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {bit id; bit err; logic [DW-1:0] dout; int lat;} exp_t;
    typedef struct {logic [1:0] cmd; logic [DW-1:0] din;} stk_t;

    exp_t          exp_q[$];
    bit            gnt_q[$];
    stk_t          stk_q[$];
    logic [DW-1:0] m_stk[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_last = 1'b1;
    bit            mon_en = 1'b0;
    int            gnt_cyc = 0;
    int            tests = 0;
    int            fails = 0;

    task automatic monitor_step();
        exp_t e;
        stk_t s;
        bit   g;
        if (!mon_en || rst) return;
        if (gnt0 || gnt1) begin
            tests++;
            gnt_cyc = cyc;
            if (gnt0 && gnt1) begin
                fails++; $display("FAIL gnt_both: gnt0=%b gnt1=%b, required one-hot", gnt0, gnt1);
            end else if (gnt_q.size() == 0) begin
                fails++; $display("FAIL gnt_unexpected: gnt1=%b, required no grant", gnt1);
            end else begin
                g = gnt_q.pop_front();
                if (gnt1 != g) begin
                    fails++; $display("FAIL gnt_order: granted id %0d, required id %0d", gnt1, g);
                end
            end
        end
        if (stk_cmd != NOOP) begin
            tests++;
            if (stk_q.size() == 0) begin
                fails++; $display("FAIL stk_cmd_unexpected: stk_cmd=%b, required 00", stk_cmd);
            end else begin
                s = stk_q.pop_front();
                if (stk_cmd != s.cmd || stk_din != s.din) begin
                    fails++;
                    $display("FAIL stk_issue: cmd=%b din=%h, required cmd=%b din=%h",
                             stk_cmd, stk_din, s.cmd, s.din);
                end
            end
        end
        if (done0 || done1) begin
            tests++;
            if (done0 && done1) begin
                fails++; $display("FAIL done_both: done0=%b done1=%b, required one-hot", done0, done1);
            end else if (exp_q.size() == 0) begin
                fails++; $display("FAIL done_unexpected: done1=%b, required no done", done1);
            end else begin
                e = exp_q.pop_front();
                if (done1 != e.id || (done1 ? err1 : err0) != e.err || dout != e.dout ||
                    (cyc - gnt_cyc) != e.lat) begin
                    fails++;
                    $display("FAIL done_resp: id=%0d err=%b dout=%h lat=%0d, required id=%0d err=%b dout=%h lat=%0d",
                             done1, (done1 ? err1 : err0), dout, cyc - gnt_cyc,
                             e.id, e.err, e.dout, e.lat);
                end
            end
        end
    endtask

    task automatic flush_model();
        exp_q.delete(); gnt_q.delete(); stk_q.delete(); m_stk.delete();
        m_dout = '0; m_last = 1'b1;
    endtask

    task automatic reset_dut();
        mon_en = 1'b0; req0 = 1'b0; req1 = 1'b0; inject = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tests++;
            if (gnt0 || gnt1 || done0 || done1 || stk_cmd != NOOP || dout != '0) begin
                fails++;
                $display("FAIL reset_out: gnt=%b%b done=%b%b stk_cmd=%b dout=%h, required all 0",
                         gnt1, gnt0, done1, done0, stk_cmd, dout);
            end
        end
        rst = 1'b0; #1;
        tests++;
        if (stk_cmd != CLR || gnt0 || gnt1 || done0 || done1) begin
            fails++;
            $display("FAIL init_clear: stk_cmd=%b gnt=%b%b done=%b%b, required 01 with no gnt/done",
                     stk_cmd, gnt1, gnt0, done1, done0);
        end
        @(posedge clk); #1;
        tests++;
        if (stk_cmd != NOOP) begin
            fails++; $display("FAIL init_once: stk_cmd=%b, required 00", stk_cmd);
        end
        flush_model();
        mon_en = 1'b1;
    endtask

    task automatic do_round(input bit r0, input logic [1:0] c0, input logic [DW-1:0] d0,
                            input bit r1, input logic [1:0] c1, input logic [DW-1:0] d1,
                            input bit inj);
        bit            ids[$];
        bit            first;
        bit            ok;
        logic [1:0]    c;
        logic [DW-1:0] d;
        bit            rej;
        if (r0 && r1) begin
            first = ~m_last;
            ids.push_back(first);
            ids.push_back(~first);
        end else if (r0) ids.push_back(1'b0);
        else if (r1) ids.push_back(1'b1);
        foreach (ids[k]) begin
            c   = ids[k] ? c1 : c0;
            d   = ids[k] ? d1 : d0;
            rej = (c == PUSH && m_stk.size() == DEPTH) || (c == POP && m_stk.size() == 0);
            gnt_q.push_back(ids[k]);
            if (!rej && c != NOOP) stk_q.push_back('{cmd: c, din: d});
            if (!rej) begin
                case (c)
                    CLR:  m_stk.delete();
                    PUSH: m_stk.push_back(d);
                    POP:  m_dout = m_stk.pop_back();
                    default: ;
                endcase
            end
            exp_q.push_back('{id: ids[k], err: rej | inj, dout: m_dout, lat: rej ? 1 : 2});
            m_last = ids[k];
        end
        inject = inj;
        req0 = r0; cmd0 = c0; din0 = d0;
        req1 = r1; cmd1 = c1; din1 = d1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if (!req0 && !req1 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        inject = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL round_timeout: %0d responses pending, required 0", exp_q.size());
            reset_dut();
        end
    endtask

    initial begin
        bit ok;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        reset_dut();

        // single push
        do_round(1, PUSH, 8'h11, 0, NOOP, 8'h00, 0);

        // tie after reset: requester 0 first, then pop returns requester 1's data
        reset_dut();
        do_round(1, PUSH, 8'hA0, 1, PUSH, 8'hB1, 0);
        do_round(0, NOOP, 8'h00, 1, POP, 8'h00, 0);

        // pop until empty, then a rejected pop keeps dout
        do_round(0, NOOP, 8'h00, 1, POP, 8'h00, 0);
        do_round(0, NOOP, 8'h00, 1, POP, 8'h33, 0);

        // fill to full, then a rejected push
        for (int i = 0; i < DEPTH; i++) do_round(1, PUSH, 8'(8'h40 + i), 0, NOOP, 8'h00, 0);
        do_round(1, PUSH, 8'h5A, 0, NOOP, 8'h00, 0);
        do_round(0, NOOP, 8'h00, 1, POP, 8'h00, 0);

        // stack error reported on a legal no-op and a legal clear
        do_round(1, NOOP, 8'h00, 1, CLR, 8'h9C, 1);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            do_round(r0, 2'($urandom_range(0, 3)), 8'($urandom), r1, 2'($urandom_range(0, 3)),
                     8'($urandom), ($urandom_range(0, 7) == 0));
        end

        // reset while a push is being issued
        mon_en = 1'b0;
        req0 = 1'b1; cmd0 = PUSH; din0 = 8'h77;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (gnt0) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok || stk_cmd != PUSH || stk_din != 8'h77) begin
            fails++;
            $display("FAIL midop_issue: gnt0=%b stk_cmd=%b stk_din=%h, required 1/10/77", gnt0, stk_cmd, stk_din);
        end
        req0 = 1'b0;
        rst = 1'b1; #1;
        tests++;
        if (stk_cmd != NOOP) begin
            fails++; $display("FAIL midop_reset_cmd: stk_cmd=%b, required 00", stk_cmd);
        end
        reset_dut();
        do_round(0, NOOP, 8'h00, 1, POP, 8'h00, 0);
        do_round(1, PUSH, 8'hC3, 1, PUSH, 8'hD4, 0);
        do_round(1, POP, 8'h00, 0, NOOP, 8'h00, 0);

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0 || gnt_q.size() != 0 || stk_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: exp=%0d gnt=%0d stk=%0d pending, required 0",
                     exp_q.size(), gnt_q.size(), stk_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
